// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the 8N1 serial receiver
package uart_rx_pkg;

  localparam int          DATA_BITS_DEFAULT = 8;
  localparam logic [15:0] MIN_DIVISOR       = 16'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  // Divisors below 2 would make the half-bit count zero, so clamp them.
  function automatic logic [15:0] eff_divisor(input logic [15:0] raw);
    return (raw < MIN_DIVISOR) ? MIN_DIVISOR : raw;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, divisor and received-byte bundle
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);

  logic                 data_line;
  logic [15:0]          uart_baud_control;
  logic [DATA_BITS-1:0] read_data;

  modport master (
    output data_line,
    output uart_baud_control,
    input  read_data
  );

  modport slave (
    input  data_line,
    input  uart_baud_control,
    output read_data
  );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - flop chain bringing the asynchronous rx line into clk domain
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw line through the chain; reset preloads idle-high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver with runtime bit period and mid-bit sampling
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  localparam int                BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          n_q, n_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [15:0]          half_m1;
  logic [15:0]          full_m1;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.data_line),
    .dout  (rx_s)
  );

  // Terminal counts derive from the divisor frozen at start detection,
  // so a host rewrite of the divisor only takes effect on the next frame.
  assign half_m1 = (n_q >> 1) - 16'd1;
  assign full_m1 = n_q - 16'd1;

  assign bus.read_data = data_q;

  // State, counters, shift register and output byte registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= MIN_DIVISOR;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
    end
  end

  // Frame sequencing: half-bit to the start midpoint, then whole bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          n_d     = eff_divisor(bus.uart_baud_control);
          cnt_d   = '0;
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == half_m1) begin
          if (!rx_s) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = DATA;
          end else begin
            // Line rose before the start midpoint: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DATA: begin
        if (cnt_q == full_m1) begin
          cnt_d   = '0;
          // LSB arrives first, so it migrates down to bit 0.
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      STOP: begin
        if (cnt_q == full_m1) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            state_d = IDLE;
          end else begin
            // Framing error or break: drop the byte and wait out the low line.
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for the 8N1 receiver
module tb_uart_rx;
  import uart_rx_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(
    .DATA_BITS   (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // seq lists the data bits in line order: seq[7] is sent first.
  typedef struct {
    logic [15:0] baud;
    logic [7:0]  seq;
    int          gap;
    logic [7:0]  exp_mid;
    logic [7:0]  exp_end;
    string       name;
  } vec_t;

  vec_t vec_a[2];
  vec_t vec_b[3];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: read_data=0x%02h expected 0x%02h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_state(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: state=%0d expected %0d", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive_bit(input logic b, input int cycles);
    bus.data_line = b;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] baud, input logic [7:0] seq,
                            input logic stop_val, input int stop_bits, input int gap,
                            input logic [7:0] exp_mid, input logic [7:0] exp_end,
                            input string name);
    int n;
    n = (baud < 16'd2) ? 2 : int'(baud);
    bus.uart_baud_control = baud;
    drive_bit(1'b0, n);
    for (int i = 0; i < 4; i++) drive_bit(seq[7-i], n);
    check8({name, "_mid"}, bus.read_data, exp_mid);
    // Rewriting the divisor mid-frame must not disturb this frame.
    bus.uart_baud_control = 16'd3;
    for (int i = 4; i < 8; i++) drive_bit(seq[7-i], n);
    drive_bit(stop_val, n * stop_bits);
    drive_bit(1'b1, gap);
    check8({name, "_end"}, bus.read_data, exp_end);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    vec_a[0] = '{baud: 16'd8,  seq: 8'b10101010, gap: 0, exp_mid: 8'h00, exp_end: 8'h55, name: "n8_55"};
    vec_a[1] = '{baud: 16'd8,  seq: 8'b00110011, gap: 4, exp_mid: 8'h55, exp_end: 8'hCC, name: "b2b_cc"};
    vec_b[0] = '{baud: 16'd16, seq: 8'b10000001, gap: 4, exp_mid: 8'h3C, exp_end: 8'h81, name: "n16_81"};
    vec_b[1] = '{baud: 16'd0,  seq: 8'b10000001, gap: 4, exp_mid: 8'h81, exp_end: 8'h81, name: "n0_81"};
    vec_b[2] = '{baud: 16'd1,  seq: 8'b11110000, gap: 4, exp_mid: 8'h81, exp_end: 8'h0F, name: "n1_0f"};

    reset                 = 1'b0;
    bus.data_line         = 1'b1;
    bus.uart_baud_control = 16'd8;
    repeat (3) @(posedge clk);
    #1;
    check8("reset_data", bus.read_data, 8'h00);
    check_state("reset_state", dut.state_q, IDLE);
    reset = 1'b1;
    drive_bit(1'b1, 50);
    check8("idle_hold", bus.read_data, 8'h00);

    for (int i = 0; i < 2; i++) begin
      send_frame(vec_a[i].baud, vec_a[i].seq, 1'b1, 1, vec_a[i].gap,
                 vec_a[i].exp_mid, vec_a[i].exp_end, vec_a[i].name);
    end

    bus.uart_baud_control = 16'd8;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 20);
    check8("glitch_data", bus.read_data, 8'hCC);
    check_state("glitch_state", dut.state_q, IDLE);

    send_frame(16'd8, 8'b10100101, 1'b0, 3, 4, 8'hCC, 8'hCC, "frame_err_a5");
    check_state("frame_err_state", dut.state_q, IDLE);
    send_frame(16'd8, 8'b00111100, 1'b1, 1, 4, 8'hCC, 8'h3C, "after_err_3c");

    for (int i = 0; i < 3; i++) begin
      send_frame(vec_b[i].baud, vec_b[i].seq, 1'b1, 1, vec_b[i].gap,
                 vec_b[i].exp_mid, vec_b[i].exp_end, vec_b[i].name);
    end

    bus.uart_baud_control = 16'd8;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b1, 8);
    bus.data_line = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check8("midframe_reset_data", bus.read_data, 8'h00);
    check_state("midframe_reset_state", dut.state_q, IDLE);
    reset = 1'b1;
    drive_bit(1'b1, 16);
    send_frame(16'd8, 8'b01101001, 1'b1, 1, 4, 8'h00, 8'h96, "post_reset_96");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
